// File: rtl/adv_mode_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adv_mode_pkg
//  Description : Shared types and constants for the ADV7513 video-mode
//                sequencer: configuration record, per-mode constants,
//                mode-code enum and sequencer state enum.
//  Revision    : 1.0  initial release
// ============================================================================
package adv_mode_pkg;

    // Active ADV7513 configuration presented to the I2C config engine.
    // pixel_rep holds the repetition factor minus one (2 => x3).
    typedef struct packed {
        logic [11:0] h_active;
        logic [11:0] v_active;
        logic [7:0]  vic;
        logic [1:0]  pixel_rep;
        logic [1:0]  clk_sel;
    } ADV7513Config;

    localparam ADV7513Config ADV7513_CONFIG_1080P  = '{h_active: 12'd1920, v_active: 12'd1080,
                                                       vic: 8'd16, pixel_rep: 2'd0, clk_sel: 2'd0};
    localparam ADV7513Config ADV7513_CONFIG_960P   = '{h_active: 12'd1280, v_active: 12'd960,
                                                       vic: 8'd0,  pixel_rep: 2'd0, clk_sel: 2'd1};
    localparam ADV7513Config ADV7513_CONFIG_480P   = '{h_active: 12'd720,  v_active: 12'd480,
                                                       vic: 8'd2,  pixel_rep: 2'd0, clk_sel: 2'd2};
    localparam ADV7513Config ADV7513_CONFIG_VGA    = '{h_active: 12'd640,  v_active: 12'd480,
                                                       vic: 8'd1,  pixel_rep: 2'd0, clk_sel: 2'd3};
    localparam ADV7513Config ADV7513_CONFIG_240PX3 = '{h_active: 12'd720,  v_active: 12'd240,
                                                       vic: 8'd8,  pixel_rep: 2'd2, clk_sel: 2'd2};

    // Mode codes as they arrive from the command FIFO.
    typedef enum logic [2:0] {
        MODE_1080P  = 3'd0,
        MODE_960P   = 3'd1,
        MODE_480P   = 3'd2,
        MODE_VGA    = 3'd3,
        MODE_240PX3 = 3'd4
    } adv_mode_e;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH      = 3'd1,
        ST_WAIT_FRAME = 3'd2,
        ST_LOAD       = 3'd3,
        ST_SETTLE     = 3'd4
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/adv_mode_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : adv_mode_sequencer_if
//  Description : Command FIFO read port (show-ahead-less: data is valid the
//                cycle after the read strobe).
//  Revision    : 1.0  initial release
// ============================================================================
interface adv_mode_sequencer_if;
    logic       rdempty;
    logic [7:0] fdata;
    logic       rdreq;

    // Sequencer side
    modport master (input rdempty, input fdata, output rdreq);
    // FIFO side
    modport slave  (output rdempty, output fdata, input rdreq);
endinterface
`default_nettype wire

// File: rtl/adv_mode_sequencer_lut.sv
`default_nettype none
// ============================================================================
//  Module      : adv_mode_lut
//  Description : Combinational mode-code to ADV7513 configuration lookup.
//                Unknown codes fall back to the 1080p configuration.
//  Revision    : 1.0  initial release
// ============================================================================
module adv_mode_lut
    import adv_mode_pkg::*;
#(
    parameter int CODE_W = 4
) (
    input  logic [CODE_W-1:0] i_code,
    output ADV7513Config      o_cfg
);

    // Pure table decode; default arm covers every out-of-range code
    always_comb begin
        o_cfg = ADV7513_CONFIG_1080P;
        case (i_code)
            CODE_W'(MODE_1080P):  o_cfg = ADV7513_CONFIG_1080P;
            CODE_W'(MODE_960P):   o_cfg = ADV7513_CONFIG_960P;
            CODE_W'(MODE_480P):   o_cfg = ADV7513_CONFIG_480P;
            CODE_W'(MODE_VGA):    o_cfg = ADV7513_CONFIG_VGA;
            CODE_W'(MODE_240PX3): o_cfg = ADV7513_CONFIG_240PX3;
            default:              o_cfg = ADV7513_CONFIG_1080P;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/adv_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : adv_mode_sequencer
//  Description : Reads video-mode codes from a command FIFO, validates them,
//                keeps the latest valid request pending and applies it on a
//                frame boundary when the ADV7513 config engine is idle, then
//                holds off further reads for a settle period.
//  Revision    : 1.0  initial release
// ============================================================================
module adv_mode_sequencer
    import adv_mode_pkg::*;
#(
    parameter int NUM_MODES     = 5,
    parameter int CODE_W        = 4,
    parameter int DEFAULT_MODE  = 0,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    adv_mode_sequencer_if.master        fifo,
    input  logic                        vsync_edge,
    input  logic                        cfg_busy,
    output logic                        cfg_load,
    output ADV7513Config                adv7513Config,
    output logic [CODE_W-1:0]           current_mode,
    output logic [7:0]                  bad_code_count
);

    localparam logic [2:0]        c_ST_IDLE       = ST_IDLE;
    localparam logic [2:0]        c_ST_FETCH      = ST_FETCH;
    localparam logic [2:0]        c_ST_WAIT_FRAME = ST_WAIT_FRAME;
    localparam logic [2:0]        c_ST_LOAD       = ST_LOAD;
    localparam logic [2:0]        c_ST_SETTLE     = ST_SETTLE;
    localparam logic [CODE_W-1:0] c_DEFAULT_CODE  = CODE_W'(DEFAULT_MODE);
    localparam logic [15:0]       c_SETTLE_LAST   = 16'(SETTLE_CYCLES - 1);

    // Elaboration-time parameter sanity
    generate
        if (DEFAULT_MODE < 0 || DEFAULT_MODE >= NUM_MODES) begin : g_bad_default
            $fatal(1, "adv_mode_sequencer: DEFAULT_MODE must be below NUM_MODES");
        end
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 65535) begin : g_bad_settle
            $fatal(1, "adv_mode_sequencer: SETTLE_CYCLES must be 1..65535");
        end
        if (CODE_W < 3 || CODE_W > 8) begin : g_bad_code_w
            $fatal(1, "adv_mode_sequencer: CODE_W must be 3..8");
        end
    endgenerate

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [CODE_W-1:0] r_pending;
    logic              r_pending_vld;
    logic [15:0]       r_settle_cnt;
    logic              r_cfg_load;
    ADV7513Config      r_cfg;
    logic [CODE_W-1:0] r_mode;
    logic [7:0]        r_bad_cnt;

    logic              w_rdreq;
    logic [CODE_W-1:0] w_code;
    logic              w_code_valid;
    logic              w_enter_load;
    logic [CODE_W-1:0] w_lut_code;
    ADV7513Config      w_lut_cfg;
    logic              w_unused_fdata;

    // Reads only happen from the two states that accept commands; the next
    // state is always FETCH, so strobes can never be back to back.
    assign w_rdreq      = ~fifo.rdempty & ((r_state == c_ST_IDLE) | (r_state == c_ST_WAIT_FRAME));
    assign fifo.rdreq   = w_rdreq;

    // Upper command bits carry no meaning for mode selection
    assign w_code         = fifo.fdata[CODE_W-1:0];
    assign w_unused_fdata = ^fifo.fdata;
    assign w_code_valid   = (32'(w_code) < NUM_MODES);

    assign w_enter_load = (w_state_nxt == c_ST_LOAD);

    // During reset the table is steered to the power-on mode so one LUT
    // serves both reset and frame-aligned loads.
    assign w_lut_code = reset ? c_DEFAULT_CODE : r_pending;

    adv_mode_lut #(
        .CODE_W (CODE_W)
    ) u_lut (
        .i_code (w_lut_code),
        .o_cfg  (w_lut_cfg)
    );

    // Next-state decode; a pending read always wins over a frame boundary
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (!fifo.rdempty) w_state_nxt = c_ST_FETCH;
            end
            c_ST_FETCH: begin
                if (!w_code_valid)
                    w_state_nxt = r_pending_vld ? c_ST_WAIT_FRAME : c_ST_IDLE;
                else if (w_code == r_mode)
                    w_state_nxt = c_ST_IDLE;
                else
                    w_state_nxt = c_ST_WAIT_FRAME;
            end
            c_ST_WAIT_FRAME: begin
                if (!fifo.rdempty)
                    w_state_nxt = c_ST_FETCH;
                else if (vsync_edge && !cfg_busy)
                    w_state_nxt = c_ST_LOAD;
            end
            c_ST_LOAD: begin
                w_state_nxt = c_ST_SETTLE;
            end
            c_ST_SETTLE: begin
                if (r_settle_cnt == 16'd0) w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Pending request: last valid code wins, a code matching the active mode cancels
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending     <= '0;
            r_pending_vld <= 1'b0;
        end else if (w_enter_load) begin
            r_pending_vld <= 1'b0;
        end else if (r_state == c_ST_FETCH && w_code_valid) begin
            if (w_code == r_mode) begin
                r_pending_vld <= 1'b0;
            end else begin
                r_pending     <= w_code;
                r_pending_vld <= 1'b1;
            end
        end
    end

    // Active configuration changes only on the edge that enters LOAD, with the load strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cfg      <= w_lut_cfg;
            r_mode     <= c_DEFAULT_CODE;
            r_cfg_load <= 1'b0;
        end else begin
            r_cfg_load <= w_enter_load;
            if (w_enter_load) begin
                r_cfg  <= w_lut_cfg;
                r_mode <= r_pending;
            end
        end
    end

    // Settle hold-off: loaded while in LOAD so SETTLE lasts exactly SETTLE_CYCLES
    always_ff @(posedge clock) begin
        if (reset)
            r_settle_cnt <= 16'd0;
        else if (r_state == c_ST_LOAD)
            r_settle_cnt <= c_SETTLE_LAST;
        else if (r_state == c_ST_SETTLE && r_settle_cnt != 16'd0)
            r_settle_cnt <= r_settle_cnt - 16'd1;
    end

    // Saturating count of rejected codes
    always_ff @(posedge clock) begin
        if (reset)
            r_bad_cnt <= 8'd0;
        else if (r_state == c_ST_FETCH && !w_code_valid && r_bad_cnt != 8'hFF)
            r_bad_cnt <= r_bad_cnt + 8'd1;
    end

    assign cfg_load       = r_cfg_load;
    assign adv7513Config  = r_cfg;
    assign current_mode   = r_mode;
    assign bad_code_count = r_bad_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adv_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adv_mode_sequencer
//  Description : Directed self-checking bench for adv_mode_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adv_mode_sequencer;
    import adv_mode_pkg::*;

    // Expected configurations written out field by field
    // {h_active, v_active, vic, pixel_rep, clk_sel}
    localparam logic [35:0] EXP_1080P  = {12'd1920, 12'd1080, 8'd16, 2'd0, 2'd0};
    localparam logic [35:0] EXP_480P   = {12'd720,  12'd480,  8'd2,  2'd0, 2'd2};
    localparam logic [35:0] EXP_VGA    = {12'd640,  12'd480,  8'd1,  2'd0, 2'd3};
    localparam logic [35:0] EXP_240PX3 = {12'd720,  12'd240,  8'd8,  2'd2, 2'd2};

    logic         clock = 1'b0;
    logic         reset;
    logic         vsync_edge;
    logic         cfg_busy;
    logic         cfg_load;
    ADV7513Config adv7513Config;
    logic [3:0]   current_mode;
    logic [7:0]   bad_code_count;

    int checks = 0;
    int errors = 0;

    int rdreq_cnt = 0;
    int load_cnt  = 0;
    int viol      = 0;
    int cyc       = 0;
    int load_cyc  = -1;
    int vs_cyc    = -1;

    adv_mode_sequencer_if bus ();

    adv_mode_sequencer #(
        .NUM_MODES     (5),
        .CODE_W        (4),
        .DEFAULT_MODE  (0),
        .SETTLE_CYCLES (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .fifo           (bus),
        .vsync_edge     (vsync_edge),
        .cfg_busy       (cfg_busy),
        .cfg_load       (cfg_load),
        .adv7513Config  (adv7513Config),
        .current_mode   (current_mode),
        .bad_code_count (bad_code_count)
    );

    always #5 clock = ~clock;

    // Cycle monitor sampling 1 ns before each rising edge
    always begin
        @(negedge clock);
        #4;
        if (bus.rdreq) rdreq_cnt++;
        if (bus.rdreq && bus.rdempty) viol++;
        if (cfg_load) begin
            load_cnt++;
            load_cyc = cyc;
        end
        if (vsync_edge && !cfg_busy) vs_cyc = cyc;
        cyc++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    // Offer one FIFO word, wait (bounded) for the read strobe, present data the cycle after
    task automatic push(input logic [7:0] val, output int waited);
        int n = 0;
        bus.rdempty = 1'b0;
        #1;
        while (!bus.rdreq && n < 40) begin
            @(negedge clock);
            #1;
            n++;
        end
        checks++;
        if (!bus.rdreq) begin
            errors++;
            $display("FAIL push_rdreq_timeout: got rdreq=0 after %0d cycles expected rdreq=1", n);
        end
        @(posedge clock);
        #1;
        bus.rdempty = 1'b1;
        bus.fdata   = val;
        @(negedge clock);
        #1;
        waited = n;
    endtask

    task automatic vsync_pulse();
        vsync_edge = 1'b1;
        @(posedge clock);
        #1;
        vsync_edge = 1'b0;
        @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(10);
        checks++; if (adv7513Config !== EXP_1080P) begin errors++; $display("FAIL reset_cfg: got %h expected %h", adv7513Config, EXP_1080P); end
        checks++; if (current_mode !== 4'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", current_mode); end
        checks++; if (rdreq_cnt != 0) begin errors++; $display("FAIL reset_rdreq: got %0d strobes expected 0", rdreq_cnt); end
        checks++; if (load_cnt != 0) begin errors++; $display("FAIL reset_cfg_load: got %0d loads expected 0", load_cnt); end
        checks++; if (bad_code_count !== 8'd0) begin errors++; $display("FAIL reset_bad_count: got %0d expected 0", bad_code_count); end
    endtask

    task automatic test_load_480p();
        int l0 = load_cnt;
        int r0 = rdreq_cnt;
        int w;
        push(8'h02, w);
        checks++; if (w != 0) begin errors++; $display("FAIL load_first_read: got wait %0d expected 0", w); end
        wait_cyc(10);
        checks++; if (load_cnt != l0) begin errors++; $display("FAIL load_early: got %0d loads expected 0", load_cnt - l0); end
        vsync_pulse();
        checks++; if (cfg_load !== 1'b1) begin errors++; $display("FAIL load_pulse: got %b expected 1", cfg_load); end
        checks++; if (adv7513Config !== EXP_480P) begin errors++; $display("FAIL load_cfg: got %h expected %h", adv7513Config, EXP_480P); end
        checks++; if (current_mode !== 4'd2) begin errors++; $display("FAIL load_mode: got %0d expected 2", current_mode); end
        // Same code again: read must wait out the 16-cycle settle, then no load
        push(8'h02, w);
        checks++; if (w != 17) begin errors++; $display("FAIL load_settle_holdoff: got %0d cycles expected 17", w); end
        wait_cyc(3);
        checks++; if (load_cnt - l0 != 1) begin errors++; $display("FAIL load_count: got %0d expected 1", load_cnt - l0); end
        checks++; if (rdreq_cnt - r0 != 2) begin errors++; $display("FAIL load_rdreq_count: got %0d expected 2", rdreq_cnt - r0); end
        checks++; if (load_cyc != vs_cyc + 1) begin errors++; $display("FAIL load_latency: got %0d expected %0d", load_cyc - vs_cyc, 1); end
    endtask

    task automatic test_last_wins();
        int l0 = load_cnt;
        int w;
        push(8'h01, w);
        wait_cyc(2);
        push(8'h03, w);
        checks++; if (w != 0) begin errors++; $display("FAIL lastwins_reread: got wait %0d expected 0", w); end
        wait_cyc(3);
        checks++; if (load_cnt != l0) begin errors++; $display("FAIL lastwins_early: got %0d loads expected 0", load_cnt - l0); end
        vsync_pulse();
        checks++; if (cfg_load !== 1'b1) begin errors++; $display("FAIL lastwins_pulse: got %b expected 1", cfg_load); end
        checks++; if (adv7513Config !== EXP_VGA) begin errors++; $display("FAIL lastwins_cfg: got %h expected %h", adv7513Config, EXP_VGA); end
        checks++; if (current_mode !== 4'd3) begin errors++; $display("FAIL lastwins_mode: got %0d expected 3", current_mode); end
        wait_cyc(20);
        // 0x53: upper nibble ignored, code 3 equals active mode
        push(8'h53, w);
        wait_cyc(4);
        checks++; if (load_cnt - l0 != 1) begin errors++; $display("FAIL lastwins_count: got %0d expected 1", load_cnt - l0); end
        checks++; if (bad_code_count !== 8'd0) begin errors++; $display("FAIL lastwins_upper_bits: got bad %0d expected 0", bad_code_count); end
        checks++; if (adv7513Config !== EXP_VGA) begin errors++; $display("FAIL lastwins_cfg_hold: got %h expected %h", adv7513Config, EXP_VGA); end
    endtask

    task automatic test_busy();
        int l0 = load_cnt;
        int w;
        push(8'h04, w);
        wait_cyc(3);
        cfg_busy = 1'b1;
        vsync_pulse();
        checks++; if (cfg_load !== 1'b0) begin errors++; $display("FAIL busy_ignored: got %b expected 0", cfg_load); end
        wait_cyc(3);
        checks++; if (adv7513Config !== EXP_VGA) begin errors++; $display("FAIL busy_cfg_hold: got %h expected %h", adv7513Config, EXP_VGA); end
        cfg_busy = 1'b0;
        wait_cyc(2);
        vsync_pulse();
        checks++; if (cfg_load !== 1'b1) begin errors++; $display("FAIL busy_second_pulse: got %b expected 1", cfg_load); end
        checks++; if (adv7513Config !== EXP_240PX3) begin errors++; $display("FAIL busy_cfg: got %h expected %h", adv7513Config, EXP_240PX3); end
        checks++; if (current_mode !== 4'd4) begin errors++; $display("FAIL busy_mode: got %0d expected 4", current_mode); end
        wait_cyc(20);
        checks++; if (load_cnt - l0 != 1) begin errors++; $display("FAIL busy_count: got %0d expected 1", load_cnt - l0); end
    endtask

    task automatic test_vsync_collision();
        int l0 = load_cnt;
        int w;
        push(8'h01, w);
        wait_cyc(3);
        // Frame boundary in the same cycle as a read: the read wins
        bus.rdempty = 1'b0;
        vsync_edge  = 1'b1;
        #1;
        checks++; if (bus.rdreq !== 1'b1) begin errors++; $display("FAIL collide_rdreq: got %b expected 1", bus.rdreq); end
        @(posedge clock);
        #1;
        bus.rdempty = 1'b1;
        bus.fdata   = 8'h02;
        vsync_edge  = 1'b0;
        wait_cyc(4);
        checks++; if (load_cnt != l0) begin errors++; $display("FAIL collide_no_load: got %0d loads expected 0", load_cnt - l0); end
        checks++; if (current_mode !== 4'd4) begin errors++; $display("FAIL collide_mode_hold: got %0d expected 4", current_mode); end
        vsync_pulse();
        checks++; if (cfg_load !== 1'b1) begin errors++; $display("FAIL collide_pulse: got %b expected 1", cfg_load); end
        checks++; if (current_mode !== 4'd2) begin errors++; $display("FAIL collide_mode: got %0d expected 2", current_mode); end
        checks++; if (adv7513Config !== EXP_480P) begin errors++; $display("FAIL collide_cfg: got %h expected %h", adv7513Config, EXP_480P); end
        wait_cyc(20);
    endtask

    task automatic test_bad_codes();
        int l0 = load_cnt;
        int w;
        push(8'h07, w);
        wait_cyc(2);
        push(8'h0F, w);
        wait_cyc(3);
        checks++; if (bad_code_count !== 8'd2) begin errors++; $display("FAIL bad_count_two: got %0d expected 2", bad_code_count); end
        checks++; if (load_cnt != l0) begin errors++; $display("FAIL bad_no_load: got %0d loads expected 0", load_cnt - l0); end
        checks++; if (adv7513Config !== EXP_480P) begin errors++; $display("FAIL bad_cfg_hold: got %h expected %h", adv7513Config, EXP_480P); end
        // Code equal to NUM_MODES is the first rejected value
        push(8'h05, w);
        wait_cyc(1);
        checks++; if (bad_code_count !== 8'd3) begin errors++; $display("FAIL bad_boundary: got %0d expected 3", bad_code_count); end
        for (int i = 0; i < 299; i++) begin
            push(((i % 2) == 0) ? 8'hFF : 8'h0A, w);
        end
        wait_cyc(2);
        checks++; if (bad_code_count !== 8'd255) begin errors++; $display("FAIL bad_saturate: got %0d expected 255", bad_code_count); end
        checks++; if (current_mode !== 4'd2) begin errors++; $display("FAIL bad_mode_hold: got %0d expected 2", current_mode); end
    endtask

    task automatic test_reset_pending();
        int l0 = load_cnt;
        int w;
        push(8'h01, w);
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
        vsync_pulse();
        checks++; if (cfg_load !== 1'b0) begin errors++; $display("FAIL rstpend_pulse: got %b expected 0", cfg_load); end
        wait_cyc(5);
        checks++; if (load_cnt != l0) begin errors++; $display("FAIL rstpend_count: got %0d loads expected 0", load_cnt - l0); end
        checks++; if (adv7513Config !== EXP_1080P) begin errors++; $display("FAIL rstpend_cfg: got %h expected %h", adv7513Config, EXP_1080P); end
        checks++; if (current_mode !== 4'd0) begin errors++; $display("FAIL rstpend_mode: got %0d expected 0", current_mode); end
        checks++; if (bad_code_count !== 8'd0) begin errors++; $display("FAIL rstpend_bad: got %0d expected 0", bad_code_count); end
        checks++; if (viol != 0) begin errors++; $display("FAIL rdreq_while_empty: got %0d strobes expected 0", viol); end
    endtask

    initial begin
        reset       = 1'b1;
        vsync_edge  = 1'b0;
        cfg_busy    = 1'b0;
        bus.rdempty = 1'b1;
        bus.fdata   = 8'h00;
        @(negedge clock);
        #1;
        test_reset();
        test_load_480p();
        test_last_wins();
        test_busy();
        test_vsync_collision();
        test_bad_codes();
        test_reset_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
